pmod_jstk_responder: RTL and testbench

SPI slave that emulates one two-axis joystick module at the far end of the existing 5-byte joystick SPI link. It captures a position and button snapshot at frame start and shifts it out on `miso`. It also captures the master's 5 command bytes and latches the LED command. It sits in the loopback/self-test path and lets one board stand in as a joystick for another player's joystick-reader instance.

---
 rtl/pmod_jstk_responder.sv | 161 ++++++++++++++++
 tb/tb_pmod_jstk_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_jstk_responder.sv
// SPI mode-0 slave that impersonates a two-axis joystick on the 5-byte joystick link.
// Snapshots position/buttons at frame start, shifts them out on miso, and latches LED commands.
module pmod_jstk_responder #(
  parameter int         FRAME_BYTES = 5,
  parameter logic [5:0] CMD_PREFIX  = 6'b100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led_cmd,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int         NBITS    = FRAME_BYTES * 8;
  localparam logic [5:0] LAST_CNT = 6'(NBITS);

  localparam logic [1:0] ARMED    = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] SHIFT    = 2'd2;
  localparam logic [1:0] WAIT_END = 2'd3;

  logic [2:0]       sclk_s_q;
  logic [2:0]       ss_s_q;
  logic [1:0]       mosi_s_q;
  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       led_q, led_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] snap;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
  assign sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];
  assign ss_rise   = ss_s_q[1] & ~ss_s_q[2];
  assign ss_fall   = ~ss_s_q[1] & ss_s_q[2];

  always_comb begin
    snap = '0;
    snap[NBITS-1 -: 40] = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8],
                           5'b0, buttons};
  end

  // tx_q is held at zero outside SHIFT, so its MSB doubles as the registered miso.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    led_d     = led_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ARMED: begin
        tx_d   = '0;
        busy_d = 1'b0;
        if (ss_s_q[1]) state_d = IDLE;
      end
      IDLE: begin
        tx_d   = '0;
        busy_d = 1'b0;
        if (ss_fall) begin
          tx_d      = snap;
          rx_d      = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          tx_d    = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (cnt_q != LAST_CNT || overrun_q) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (rx_q[NBITS-1 -: 6] == CMD_PREFIX) led_d = rx_q[NBITS-7 -: 2];
          end
        end else if (cnt_q == LAST_CNT) begin
          tx_d    = '0;
          state_d = WAIT_END;
          if (sclk_rise) overrun_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_d  = {rx_q[NBITS-2:0], mosi_s_q[1]};
            cnt_d = cnt_q + 6'd1;
          end
          if (sclk_fall) tx_d = {tx_q[NBITS-2:0], 1'b0};
        end
      end
      default: begin
        tx_d = '0;
        if (sclk_rise) overrun_d = 1'b1;
        if (ss_rise) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (overrun_q || sclk_rise) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (rx_q[NBITS-1 -: 6] == CMD_PREFIX) led_d = rx_q[NBITS-7 -: 2];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q  <= '0;
      ss_s_q    <= '0;
      mosi_s_q  <= '0;
      state_q   <= ARMED;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      led_q     <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sclk_s_q  <= {sclk_s_q[1:0], sclk};
      ss_s_q    <= {ss_s_q[1:0], ss};
      mosi_s_q  <= {mosi_s_q[0], mosi};
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      led_q     <= led_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign miso       = tx_q[NBITS-1];
  assign led_cmd    = led_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Directed bench for pmod_jstk_responder: a bit-banged SPI master, a queue of expected
// miso bytes, and a pulse monitor for frame_done/frame_err.
module tb_pmod_jstk_responder;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, ss, mosi, miso;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [1:0] led_cmd;
  logic       frame_done, frame_err, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int   done_pulses = 0, done_cyc = 0, err_pulses = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;
  logic [1:0] led_at_done = 2'b00;
  logic busy_at_done = 1'b1, busy_at_err = 1'b1;

  pmod_jstk_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons), .led_cmd(led_cmd),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    done_prev <= frame_done;
    err_prev  <= frame_err;
    if (frame_done) begin
      done_cyc <= done_cyc + 1;
      if (!done_prev) begin
        done_pulses  <= done_pulses + 1;
        led_at_done  <= led_cmd;
        busy_at_done <= busy;
      end
    end
    if (frame_err && !err_prev) begin
      err_pulses  <= err_pulses + 1;
      busy_at_err <= busy;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no end of test, required completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int n);
    logic [7:0] b [5];
    b[0] = x_pos[7:0];
    b[1] = {6'b0, x_pos[9:8]};
    b[2] = y_pos[7:0];
    b[3] = {6'b0, y_pos[9:8]};
    b[4] = {5'b0, buttons};
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  // One SPI frame: nbits SCLK pulses, command byte c0 followed by zeros on mosi.
  task automatic run_frame(input int nbits, input logic [7:0] c0, input int nchk,
                           input int chg_bit, input logic [9:0] new_x, input bit lower_ss);
    logic [39:0] mv;
    logic [7:0]  rb;
    logic [7:0]  e;
    mv = {c0, 32'h0};
    rb = 8'h00;
    mosi = mv[39];
    if (lower_ss) ss = 1'b0;
    tick(HALF);
    for (int k = 0; k < nbits; k++) begin
      sclk = 1'b1;
      rb = {rb[6:0], miso};
      if (k < 40 && (k % 8) == 7 && (k / 8) < nchk) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("miso_byte%0d", k / 8), {24'h0, rb}, {24'h0, e});
          $display("byte %0d read 0x%02h expected 0x%02h", k / 8, rb, e);
        end
      end
      if (k == chg_bit) x_pos = new_x;
      if (k == 5 && lower_ss) chk("busy_mid_frame", {31'h0, busy}, 32'd1);
      tick(HALF);
      sclk = 1'b0;
      mosi = (k + 1 < 40) ? mv[39 - (k + 1)] : 1'b0;
      tick(HALF);
    end
    ss = 1'b1;
    tick(20);
  endtask

  int d0, dc0, e0;

  task automatic snap_counts();
    d0 = done_pulses; dc0 = done_cyc; e0 = err_pulses;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; ss = 1'b0; mosi = 1'b0;
    x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
    tick(5);
    chk("rst_miso", {31'h0, miso}, 32'd0);
    chk("rst_led", {30'h0, led_cmd}, 32'd0);
    chk("rst_done", {31'h0, frame_done}, 32'd0);
    chk("rst_err", {31'h0, frame_err}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Frame started before reset released: must be ignored.
    snap_counts();
    run_frame(40, 8'h81, 0, -1, 10'h000, 1'b0);
    chk("armed_no_done", done_pulses - d0, 0);
    chk("armed_no_err", err_pulses - e0, 0);
    chk("armed_led", {30'h0, led_cmd}, 32'd0);
    $display("frame 1 (armed) done=%0d err=%0d", done_pulses - d0, err_pulses - e0);

    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    push_exp(5);
    snap_counts();
    run_frame(40, 8'h81, 5, -1, 10'h000, 1'b1);
    chk("f2_done_pulses", done_pulses - d0, 1);
    chk("f2_done_width", done_cyc - dc0, 1);
    chk("f2_no_err", err_pulses - e0, 0);
    chk("f2_led", {30'h0, led_cmd}, 32'd1);
    chk("f2_led_at_done", {30'h0, led_at_done}, 32'd1);
    chk("f2_busy_at_done", {31'h0, busy_at_done}, 32'd0);
    $display("frame 2 done=%0d led=%b", done_pulses - d0, led_cmd);

    push_exp(5);
    snap_counts();
    run_frame(40, 8'h43, 5, -1, 10'h000, 1'b1);
    chk("f3_done", done_pulses - d0, 1);
    chk("f3_led_kept", {30'h0, led_cmd}, 32'd1);
    $display("frame 3 done=%0d led=%b", done_pulses - d0, led_cmd);

    push_exp(2);
    snap_counts();
    run_frame(17, 8'h82, 2, -1, 10'h000, 1'b1);
    chk("f4_err", err_pulses - e0, 1);
    chk("f4_no_done", done_pulses - d0, 0);
    chk("f4_led_kept", {30'h0, led_cmd}, 32'd1);
    chk("f4_busy_at_err", {31'h0, busy_at_err}, 32'd0);
    chk("f4_busy_after", {31'h0, busy}, 32'd0);
    $display("frame 4 (short) err=%0d done=%0d", err_pulses - e0, done_pulses - d0);

    push_exp(5);
    snap_counts();
    run_frame(41, 8'h82, 5, -1, 10'h000, 1'b1);
    chk("f5_err", err_pulses - e0, 1);
    chk("f5_no_done", done_pulses - d0, 0);
    chk("f5_led_kept", {30'h0, led_cmd}, 32'd1);
    $display("frame 5 (overrun) err=%0d done=%0d", err_pulses - e0, done_pulses - d0);

    x_pos = 10'h000;
    push_exp(5);
    snap_counts();
    run_frame(40, 8'h82, 5, 3, 10'h3FF, 1'b1);
    chk("f6_done", done_pulses - d0, 1);
    chk("f6_led", {30'h0, led_cmd}, 32'd2);
    $display("frame 6 (x change mid-frame) done=%0d led=%b", done_pulses - d0, led_cmd);

    push_exp(5);
    snap_counts();
    run_frame(40, 8'h80, 5, -1, 10'h000, 1'b1);
    chk("f7_done", done_pulses - d0, 1);
    chk("f7_led", {30'h0, led_cmd}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("frame 7 done=%0d led=%b", done_pulses - d0, led_cmd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
